// File: rtl/drv_pkg.sv
// Shared types and constants for the stream driver: operating modes, FSM states,
// s2cif packet width and a saturating counter helper.
package drv_pkg;

  typedef enum logic {
    DRV_STREAM,
    DRV_FREE
  } drv_mode_e;

  typedef enum logic [1:0] {
    FETCH,
    DRAIN,
    DONE,
    ERROR
  } drv_state_e;

  localparam int PKT_BITS  = 64;
  localparam int DRV_CNT_W = 32;
  localparam int DRV_RET_W = 32;

  function automatic logic [DRV_CNT_W-1:0] sat_inc(input logic [DRV_CNT_W-1:0] v);
    return (v == '1) ? v : v + DRV_CNT_W'(1);
  endfunction

endpackage

// File: rtl/drv_stream_if.sv
// s2cif bus between a driver channel and the C model: one call per cycle with a
// same-cycle response, a static setup result and an error report strobe.
interface drv_stream_if;
  import drv_pkg::*;

  logic                        call;
  logic [7:0]                  id;
  logic [7:0]                  fn;
  logic signed [DRV_RET_W-1:0] ret;
  logic [PKT_BITS-1:0]         data;
  logic signed [DRV_RET_W-1:0] setup_ret;
  logic                        report;
  logic signed [DRV_RET_W-1:0] report_ret;

  modport master (
    output call, id, fn, report, report_ret,
    input  ret, data, setup_ret
  );

  modport slave (
    input  call, id, fn, report, report_ret,
    output ret, data, setup_ret
  );

endinterface

// File: rtl/drv_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata shows the head entry whenever
// the FIFO is non-empty. Push when full and pop when empty are ignored.
module drv_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);

endmodule

// File: rtl/drv_stream.sv
// One driver channel: prefetches words from the C model over s2cif into a FIFO and
// presents them to the DUT input with valid/ready (or free-running), flagging last/done/err.
module drv_stream
  import drv_pkg::*;
#(
  parameter int        id    = 0,
  parameter int        FN    = 0,
  parameter int        WIDTH = 8,
  parameter int        DEPTH = 4,
  parameter drv_mode_e MODE  = DRV_STREAM
) (
  input  logic                 clk,
  input  logic                 rst,
  drv_stream_if.master         s2cif,
  output logic [WIDTH-1:0]     dout_data,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 dout_last,
  output logic                 done,
  output logic                 err,
  output logic [DRV_CNT_W-1:0] xfer_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  drv_state_e       state, state_next;
  logic             eod;
  logic [CW-1:0]    count;
  logic             empty, full;
  logic [WIDTH-1:0] head;
  logic             setup_fail;
  logic             call, call_eod, call_err, push, pop;

  // The setup result is fixed for the whole simulation, so it is used directly.
  assign setup_fail = (s2cif.setup_ret != 0);

  drv_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (s2cif.data[WIDTH-1:0]),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= setup_fail ? ERROR : FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (setup_fail || call_err) state_next = ERROR;
        else if (call_eod)          state_next = DRAIN;
      end
      DRAIN: if (empty || (count == CW'(1) && pop)) state_next = DONE;
      default: ;
    endcase
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    call       = 1'b0;
    dout_valid = 1'b0;
    if (state == FETCH && !rst && !setup_fail && !full) call = 1'b1;
    if (!rst && !setup_fail && !empty && state != ERROR) dout_valid = 1'b1;
    call_eod  = call && (s2cif.ret < 0);
    call_err  = call && (s2cif.ret > 0);
    push      = call && (s2cif.ret == 0);
    pop       = dout_valid && (MODE == DRV_FREE || dout_ready);
    dout_data = dout_valid ? head : '0;
    // End-of-data returned by this cycle's call already marks a lone head word as last.
    dout_last = dout_valid && (count == CW'(1)) && (eod || call_eod);
    done      = !rst && (state == DONE);
    err       = setup_fail || (!rst && state == ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eod      <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      if (call_eod) eod      <= 1'b1;
      if (pop)      xfer_cnt <= sat_inc(xfer_cnt);
    end
  end

  assign s2cif.call       = call;
  assign s2cif.id         = 8'(id);
  assign s2cif.fn         = 8'(FN);
  assign s2cif.report     = call_err;
  assign s2cif.report_ret = s2cif.ret;

endmodule

// File: tb/tb_drv_stream.sv
// Scoreboard bench for drv_stream: table-driven C models on three channels
// (stream, free-running, failed setup); monitors compare every delivered word.
module tb_drv_stream;
  import drv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_free, ready;
  logic f_ready = 1'b0;
  logic e_ready = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  drv_stream_if s_if ();
  drv_stream_if f_if ();
  drv_stream_if e_if ();

  logic [7:0]  s_data;  logic s_valid, s_last, s_done, s_err;  logic [31:0] s_xfer;
  logic [15:0] f_data;  logic f_valid, f_last, f_done, f_err;  logic [31:0] f_xfer;
  logic [7:0]  e_data;  logic e_valid, e_last, e_done, e_err;  logic [31:0] e_xfer;

  drv_stream #(.id(1), .FN(2), .WIDTH(8), .DEPTH(4), .MODE(DRV_STREAM)) u_stream (
    .clk(clk), .rst(rst), .s2cif(s_if), .dout_data(s_data), .dout_valid(s_valid),
    .dout_ready(ready), .dout_last(s_last), .done(s_done), .err(s_err), .xfer_cnt(s_xfer));

  drv_stream #(.id(2), .FN(3), .WIDTH(16), .DEPTH(4), .MODE(DRV_FREE)) u_free (
    .clk(clk), .rst(rst_free), .s2cif(f_if), .dout_data(f_data), .dout_valid(f_valid),
    .dout_ready(f_ready), .dout_last(f_last), .done(f_done), .err(f_err), .xfer_cnt(f_xfer));

  drv_stream #(.id(3), .FN(4), .WIDTH(8), .DEPTH(4), .MODE(DRV_STREAM)) u_setup (
    .clk(clk), .rst(rst), .s2cif(e_if), .dout_data(e_data), .dout_valid(e_valid),
    .dout_ready(e_ready), .dout_last(e_last), .done(e_done), .err(e_err), .xfer_cnt(e_xfer));

  // C models: each call consumes the next table entry.
  localparam int TBL = 48;
  int         s_ret [TBL];
  logic [7:0] s_val [TBL];
  int         s_n = 0, s_idx = 0, s_calls = 0, s_reports = 0;
  int          f_ret [4];
  logic [15:0] f_val [4];
  int          f_idx = 0, f_calls = 0;
  int          e_calls = 0;
  logic        e_valid_seen = 1'b0;

  assign s_if.setup_ret = 0;
  assign s_if.ret       = (s_idx < TBL) ? s_ret[s_idx] : -1;
  assign s_if.data      = PKT_BITS'((s_idx < TBL) ? s_val[s_idx] : 8'h00);
  assign f_if.setup_ret = 0;
  assign f_if.ret       = (f_idx < 4) ? f_ret[f_idx] : -1;
  assign f_if.data      = PKT_BITS'((f_idx < 4) ? f_val[f_idx] : 16'h0000);
  assign e_if.setup_ret = 1;
  assign e_if.ret       = 0;
  assign e_if.data      = PKT_BITS'(8'h5A);

  always @(posedge clk) begin
    if (s_if.call)   begin s_idx <= s_idx + 1; s_calls <= s_calls + 1; end
    if (s_if.report) s_reports <= s_reports + 1;
    if (f_if.call)   begin f_idx <= f_idx + 1; f_calls <= f_calls + 1; end
    if (e_if.call)   e_calls <= e_calls + 1;
  end

  task automatic sput(input int r, input logic [7:0] v);
    s_ret[s_n] = r;
    s_val[s_n] = v;
    s_n++;
  endtask

  // Scoreboard queues and monitors.
  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;
  exp_t s_q[$];
  exp_t f_q[$];

  task automatic exp_s(input logic [15:0] d, input logic l);
    s_q.push_back('{data: d, last: l});
  endtask

  always @(negedge clk) begin
    if (s_valid && ready) begin
      if (s_q.size() == 0) check("stream_extra_word", s_q.size(), 1);
      else begin
        exp_t e;
        e = s_q.pop_front();
        check("stream_data", s_data, e.data);
        check("stream_last", s_last, e.last);
      end
    end
    if (f_valid) begin
      if (f_q.size() == 0) check("free_extra_word", f_q.size(), 1);
      else begin
        exp_t e;
        e = f_q.pop_front();
        check("free_data", f_data, e.data);
        check("free_last", f_last, e.last);
      end
    end
    if (e_valid) e_valid_seen <= 1'b1;
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_stream();
    sync(); rst = 1'b1;
    sync(); rst = 1'b0;
  endtask

  task automatic wait_done_s(input int max, output int cyc);
    cyc = 0;
    while (!s_done && cyc < max) begin
      edges(1);
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cb, rb, cyc;
    logic stable;
    rst = 1'b1; rst_free = 1'b1; ready = 1'b0;
    for (int i = 0; i < TBL; i++) begin s_ret[i] = -1; s_val[i] = 8'h00; end
    for (int i = 1; i <= 10; i++) sput(0, 8'(i));   // stream A
    sput(-1, 8'h00);
    for (int i = 1; i <= 10; i++) sput(0, 8'(i));   // stream B
    sput(-1, 8'h00);
    for (int i = 8'h11; i <= 8'h14; i++) sput(0, 8'(i));
    sput(3, 8'h15);                                  // error on 5th call
    for (int i = 8'h16; i <= 8'h18; i++) sput(0, 8'(i));
    sput(-1, 8'h00);
    for (int i = 8'h21; i <= 8'h26; i++) sput(0, 8'(i));
    sput(-1, 8'h00);
    f_ret[0] = 0; f_val[0] = 16'hBEEF;
    f_ret[1] = 0; f_val[1] = 16'h1234;
    f_ret[2] = -1; f_val[2] = 16'h0000;
    f_ret[3] = -1; f_val[3] = 16'h0000;

    @(negedge clk);
    check("setup_err_time0", e_err, 1);
    edges(1);
    check("rst_valid", s_valid, 0);
    check("rst_data", s_data, 0);
    check("rst_last", s_last, 0);
    check("rst_done", s_done, 0);
    check("rst_err", s_err, 0);
    check("rst_xfer", s_xfer, 0);
    check("setup_err_in_rst", e_err, 1);

    // Free-running, WIDTH=16, dout_ready held low.
    f_q.push_back('{data: 16'hBEEF, last: 1'b0});
    f_q.push_back('{data: 16'h1234, last: 1'b1});
    sync(); rst_free = 1'b0;
    edges(3);
    check("free_valid_after", f_valid, 0);
    check("free_data_after", f_data, 0);
    check("free_err", f_err, 0);
    edges(1);
    check("free_done", f_done, 1);
    check("free_xfer", f_xfer, 2);
    check("free_calls", f_calls, 3);
    check("free_queue_empty", f_q.size(), 0);

    // Stream A: ready always high.
    for (int i = 1; i <= 10; i++) exp_s(16'(i), i == 10);
    ready = 1'b1;
    cb = s_calls;
    reset_stream();
    edges(11);
    check("a_done_early", s_done, 0);
    edges(1);
    check("a_done", s_done, 1);
    check("a_xfer", s_xfer, 10);
    check("a_calls", s_calls - cb, 11);
    check("a_queue_empty", s_q.size(), 0);

    // Stream B: backpressure for 20 cycles.
    for (int i = 1; i <= 10; i++) exp_s(16'(i), i == 10);
    ready = 1'b0;
    cb = s_calls;
    reset_stream();
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      edges(1);
      if (!(s_valid === 1'b1 && s_data === 8'h01)) stable = 1'b0;
    end
    check("b_hold_stable", stable, 1);
    check("b_hold_calls", s_calls - cb, 4);
    sync(); ready = 1'b1;
    edges(1);
    check("b_no_bypass_calls", s_calls - cb, 4);
    wait_done_s(40, cyc);
    check("b_done_in_time", s_done, 1);
    check("b_xfer", s_xfer, 10);
    check("b_calls", s_calls - cb, 11);
    check("b_queue_empty", s_q.size(), 0);

    // Error on the 5th call, then recovery by reset.
    for (int i = 8'h11; i <= 8'h14; i++) exp_s(16'(i), 1'b0);
    cb = s_calls; rb = s_reports;
    reset_stream();
    edges(4);
    check("c_err_before", s_err, 0);
    edges(1);
    check("c_err", s_err, 1);
    check("c_err_valid", s_valid, 0);
    check("c_err_data", s_data, 0);
    edges(5);
    check("c_err_sticky", s_err, 1);
    check("c_err_calls", s_calls - cb, 5);
    check("c_err_report", s_reports - rb, 1);
    check("c_err_xfer", s_xfer, 4);
    exp_s(16'h16, 1'b0); exp_s(16'h17, 1'b0); exp_s(16'h18, 1'b1);
    reset_stream();
    edges(1);
    check("c_err_cleared", s_err, 0);
    wait_done_s(20, cyc);
    check("c_done_in_time", s_done, 1);
    check("c_resume_xfer", s_xfer, 3);
    check("c_queue_empty", s_q.size(), 0);

    // Reset mid-stream with three words buffered.
    exp_s(16'h21, 1'b0); exp_s(16'h25, 1'b0); exp_s(16'h26, 1'b1);
    cb = s_calls;
    reset_stream();
    sync();
    sync(); ready = 1'b0;
    sync();
    sync(); rst = 1'b1;
    @(negedge clk);
    check("d_pre_rst_xfer", s_xfer, 1);
    check("d_rst_valid", s_valid, 0);
    sync(); rst = 1'b0; ready = 1'b1;
    @(negedge clk);
    check("d_post_rst_valid", s_valid, 0);
    check("d_post_rst_xfer", s_xfer, 0);
    wait_done_s(20, cyc);
    check("d_done_in_time", s_done, 1);
    check("d_xfer", s_xfer, 2);
    check("d_calls", s_calls - cb, 7);
    check("d_queue_empty", s_q.size(), 0);

    // Failed setup channel over the whole run.
    check("setup_err_end", e_err, 1);
    check("setup_no_calls", e_calls, 0);
    check("setup_never_valid", e_valid_seen, 0);
    check("setup_done", e_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
